cook_timer: RTL

- Countdown timer at the far end of the magnetron-control interface. It consumes mag_on and produces timer_done for the magnetron controller.
- Cook time is entered from the keypad as BCD digits in MM:SS form.
- The count decrements once per 1 Hz tick while mag_on is high.
- timer_done is asserted when the count reaches 00:00. The digits also drive the display decoders.

---
 rtl/microwave_pkg.sv | 18 +
 rtl/bcd_down_digit.sv | 35 +++
 rtl/cook_timer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave controller blocks: BCD digit width,
// digit limits used by the cook timer, and the 1 Hz prescaler divide ratio.
package microwave_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] BCD_NINE     = 4'd9;
    localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;

    // Clock cycles per 1 Hz tick; shared with the prescaler that produces tick_1hz.
    localparam int TICK_DIV = 50_000_000;

    // True when the value is a legal decimal digit (0..9).
    function automatic logic is_bcd(input logic [BCD_W-1:0] d);
        return d <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a down-counter. Priority: clear, decrement, load.
// On decrement from zero the digit takes wrap_val and raises borrow_out
// so the next more-significant digit decrements in the same cycle.
module bcd_down_digit #(
    parameter int DIGIT_W = microwave_pkg::BCD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_en,
    input  logic               load_en,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               clr,
    input  logic [DIGIT_W-1:0] wrap_val,
    output logic [DIGIT_W-1:0] digit,
    output logic               borrow_out
);

    localparam logic [DIGIT_W-1:0] ONE = DIGIT_W'(1);

    assign borrow_out = dec_en & (digit == '0);

    // Digit register: clear beats decrement, decrement beats load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (dec_en) begin
            digit <= (digit == '0) ? wrap_val : (digit - ONE);
        end else if (load_en) begin
            digit <= load_val;
        end
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: MM:SS BCD count entered from the keypad by shifting
// digits in from the right, counted down once per 1 Hz tick while the
// magnetron runs. timer_done flags a count of 00:00 and is registered from
// the next-state count so it changes on the same edge as the digits.
module cook_timer #(
    parameter int                  DIGIT_W      = microwave_pkg::BCD_W,
    parameter logic [DIGIT_W-1:0]  MAX_SEC_TENS = microwave_pkg::MAX_SEC_TENS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               keyn,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               clrn,
    input  logic               mag_on,
    input  logic               tick_1hz,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               timer_done
);

    import microwave_pkg::*;

    localparam logic [DIGIT_W-1:0] ONE  = DIGIT_W'(1);
    localparam logic [DIGIT_W-1:0] NINE = DIGIT_W'(BCD_NINE);

    logic keyn_q;
    logic key_acc;
    logic count_nz;
    logic count_is_one;
    logic cnt_en;
    logic clr;
    logic so_borrow;
    logic st_borrow;
    logic mo_borrow;
    logic mt_borrow;
    logic done_nxt;

    // Keypad strobe history for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyn_q <= 1'b1;
        end else begin
            keyn_q <= keyn;
        end
    end

    // A key is taken only on a falling strobe, with a legal digit, while idle.
    assign key_acc = keyn_q & ~keyn & ~mag_on & clrn & is_bcd(4'(key_digit));

    assign clr          = ~clrn;
    assign count_nz     = (min_tens | min_ones | sec_tens | sec_ones) != '0;
    assign count_is_one = (min_tens == '0) & (min_ones == '0) &
                          (sec_tens == '0) & (sec_ones == ONE);
    assign cnt_en       = mag_on & tick_1hz & clrn & count_nz;

    bcd_down_digit #(.DIGIT_W(DIGIT_W)) u_sec_ones (
        .clk        (clk),
        .rst        (rst),
        .dec_en     (cnt_en),
        .load_en    (key_acc),
        .load_val   (key_digit),
        .clr        (clr),
        .wrap_val   (NINE),
        .digit      (sec_ones),
        .borrow_out (so_borrow)
    );

    // Seconds tens may hold 6..9 after entry; it only reloads to MAX_SEC_TENS on borrow.
    bcd_down_digit #(.DIGIT_W(DIGIT_W)) u_sec_tens (
        .clk        (clk),
        .rst        (rst),
        .dec_en     (so_borrow),
        .load_en    (key_acc),
        .load_val   (sec_ones),
        .clr        (clr),
        .wrap_val   (MAX_SEC_TENS),
        .digit      (sec_tens),
        .borrow_out (st_borrow)
    );

    bcd_down_digit #(.DIGIT_W(DIGIT_W)) u_min_ones (
        .clk        (clk),
        .rst        (rst),
        .dec_en     (st_borrow),
        .load_en    (key_acc),
        .load_val   (sec_tens),
        .clr        (clr),
        .wrap_val   (NINE),
        .digit      (min_ones),
        .borrow_out (mo_borrow)
    );

    // Minutes tens never wraps because countdown stops at 00:00; its borrow is unused.
    bcd_down_digit #(.DIGIT_W(DIGIT_W)) u_min_tens (
        .clk        (clk),
        .rst        (rst),
        .dec_en     (mo_borrow),
        .load_en    (key_acc),
        .load_val   (min_ones),
        .clr        (clr),
        .wrap_val   (NINE),
        .digit      (min_tens),
        .borrow_out (mt_borrow)
    );

    // Next-state zero flag: a decrement reaches zero only from 00:01; a key
    // entry gives zero only when every shifted-in digit is zero.
    always_comb begin
        done_nxt = timer_done;
        if (!clrn) begin
            done_nxt = 1'b1;
        end else if (cnt_en) begin
            done_nxt = count_is_one;
        end else if (key_acc) begin
            done_nxt = ({min_ones, sec_tens, sec_ones, key_digit} == '0);
        end
    end

    // timer_done register, aligned with the digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_done <= 1'b1;
        end else begin
            timer_done <= done_nxt;
        end
    end

endmodule
